// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared types, widths and helpers for the data-memory responder
//               (state encoding, word/byte-enable widths, address check and
//               byte-lane merge).
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

  localparam int DM_WORD_W = 32;
  localparam int DM_BE_W   = 4;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dmState_t;

  // Request is unusable when not word aligned or beyond the last stored word
  function automatic logic dmAddrErr(input logic [31:0] addr, input int depthWords);
    logic [31:0] wordIdx;
    wordIdx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (wordIdx >= 32'(depthWords));
  endfunction

  // Replace the byte lanes selected by be, keep the others
  function automatic logic [DM_WORD_W-1:0] dmMergeBytes(
    input logic [DM_WORD_W-1:0] oldWord,
    input logic [DM_WORD_W-1:0] newWord,
    input logic [DM_BE_W-1:0]   be
  );
    logic [DM_WORD_W-1:0] res;
    res = oldWord;
    for (int i = 0; i < DM_BE_W; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = newWord[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage : dm_pkg
`default_nettype wire

// File: rtl/dm_store.sv
`default_nettype none
// ============================================================================
// Module      : dm_store
// Description : Word-organised storage array for the data-memory responder.
//               Asynchronous clear of every word, one byte-enable write port,
//               one combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_store
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wrEn,
  input  logic [IDX_W-1:0]     wrIdx,
  input  logic [DM_BE_W-1:0]   wrBe,
  input  logic [DM_WORD_W-1:0] wrData,
  input  logic [IDX_W-1:0]     rdIdx,
  output logic [DM_WORD_W-1:0] rdData
);

  logic [DM_WORD_W-1:0] r_mem [DEPTH_WORDS];

  // Clear all words on reset; otherwise merge enabled byte lanes into the addressed word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wrEn) begin
      r_mem[wrIdx] <= dmMergeBytes(r_mem[wrIdx], wrData, wrBe);
    end
  end

  assign rdData = r_mem[rdIdx];

endmodule : dm_store
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder
// Description : Memory-side end of the CPU load/store interface. Accepts one
//               word-aligned request at a time (valid/ready), waits LATENCY
//               cycles, commits the access and returns load data or a store
//               acknowledge, flagging misaligned/out-of-range addresses.
//               Optional store trace enabled by defining DM_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWr,
  input  logic [31:0]          reqAddr,
  input  logic [DM_BE_W-1:0]   reqBe,
  input  logic [DM_WORD_W-1:0] reqWdata,
  input  logic [31:0]          reqPc,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [DM_WORD_W-1:0] rspRdata,
  output logic                 rspErr
);

  localparam int         c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // The counter runs LATENCY..0 inside WAIT so that the response appears
  // LATENCY+1 edges after the accept edge (one latch cycle plus LATENCY waits).
  localparam logic [3:0] c_WAIT_INIT = 4'(LATENCY);

  dmState_t             r_state;
  logic [3:0]           r_waitCnt;
  logic                 r_reqReady;
  logic                 r_rspValid;
  logic [DM_WORD_W-1:0] r_rspRdata;
  logic                 r_rspErr;

  logic                 r_latWr;
  logic [31:0]          r_latAddr;
  logic [DM_BE_W-1:0]   r_latBe;
  logic [DM_WORD_W-1:0] r_latWdata;
  logic [31:0]          r_latPc;

  logic                 w_commit;
  logic                 w_err;
  logic                 w_memWe;
  logic [c_IDX_W-1:0]   w_memIdx;
  logic [DM_WORD_W-1:0] w_memRdata;

  assign w_commit = (r_state == DM_WAIT) && (r_waitCnt == 4'd0);
  assign w_err    = dmAddrErr(r_latAddr, DEPTH_WORDS);
  assign w_memWe  = w_commit && r_latWr && !w_err;
  assign w_memIdx = r_latAddr[c_IDX_W+1:2];

  dm_store #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (c_IDX_W)
  ) u_store (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (w_memWe),
    .wrIdx  (w_memIdx),
    .wrBe   (r_latBe),
    .wrData (r_latWdata),
    .rdIdx  (w_memIdx),
    .rdData (w_memRdata)
  );

  // Request/response FSM with registered handshake outputs and request latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= DM_IDLE;
      r_waitCnt  <= '0;
      r_reqReady <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
      r_latWr    <= 1'b0;
      r_latAddr  <= '0;
      r_latBe    <= '0;
      r_latWdata <= '0;
      r_latPc    <= '0;
    end else begin
      case (r_state)
        DM_IDLE: begin
          r_reqReady <= 1'b1;
          if (reqValid && r_reqReady) begin
            r_state    <= DM_WAIT;
            r_waitCnt  <= c_WAIT_INIT;
            r_reqReady <= 1'b0;
            r_latWr    <= reqWr;
            r_latAddr  <= reqAddr;
            r_latBe    <= reqBe;
            r_latWdata <= reqWdata;
            r_latPc    <= reqPc;
          end
        end
        DM_WAIT: begin
          if (r_waitCnt == 4'd0) begin
            r_state    <= DM_RESP;
            r_rspValid <= 1'b1;
            r_rspErr   <= w_err;
            r_rspRdata <= (w_err || r_latWr) ? '0 : w_memRdata;
          end else begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end
        DM_RESP: begin
          if (rspReady) begin
            r_state    <= DM_IDLE;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
            r_reqReady <= 1'b1;
          end
        end
        default: begin
          r_state    <= DM_IDLE;
          r_reqReady <= 1'b0;
        end
      endcase
    end
  end

  assign reqReady = r_reqReady;
  assign rspValid = r_rspValid;
  assign rspRdata = r_rspRdata;
  assign rspErr   = r_rspErr;

`ifdef DM_TRACE_EN
  // Print each committed store that touches at least one byte, with the resulting word
  always_ff @(posedge clk) begin
    if (reset && w_memWe && (r_latBe != '0)) begin
      $display("@%h: *%h <= %h", r_latPc, {r_latAddr[31:2], 2'b00},
               dmMergeBytes(w_memRdata, r_latWdata, r_latBe));
    end
  end
`else
  // The latched PC only feeds the trace
  logic w_unusedPc;
  assign w_unusedPc = ^r_latPc;
`endif

endmodule : dm_responder
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_responder
// Description : Self-checking bench for dm_responder: directed corner cases
//               followed by randomized loads/stores against a word-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqWr    = 1'b0;
  logic [31:0] reqAddr  = '0;
  logic [3:0]  reqBe    = '0;
  logic [31:0] reqWdata = '0;
  logic [31:0] reqPc    = '0;
  logic        rspReady = 1'b0;
  logic        reqReady;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        rspErr;

  int          nTests = 0;
  int          nFail  = 0;
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  dm_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqWr    (reqWr),
    .reqAddr  (reqAddr),
    .reqBe    (reqBe),
    .reqWdata (reqWdata),
    .reqPc    (reqPc),
    .rspValid (rspValid),
    .rspReady (rspReady),
    .rspRdata (rspRdata),
    .rspErr   (rspErr)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit addrBad(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Called #1 after an edge with the request already driven
  task automatic waitAccept(output bit ok);
    bit rdy;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rdy = reqReady;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic doTxn(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input int hold, input bit earlyRdy);
    bit          ok;
    int          lat;
    bit          expErr;
    logic [31:0] expData;
    logic [31:0] word;
    reqValid = 1'b1; reqWr = wr; reqAddr = addr; reqBe = be; reqWdata = wdata;
    reqPc = $urandom; rspReady = 1'b0;
    waitAccept(ok);
    checkEq("accept", 32'(ok), 32'd1);
    reqValid = 1'b0;
    if (!ok) return;
    // Request fields are free to change once accepted
    reqWr = 1'($urandom); reqAddr = $urandom; reqBe = 4'($urandom); reqWdata = $urandom;
    rspReady = earlyRdy;

    expErr  = addrBad(addr);
    expData = '0;
    if (!expErr) begin
      word = model[addr / 4];
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
        model[addr / 4] = word;
      end else begin
        expData = word;
      end
    end

    lat = 0;
    while (!rspValid && lat < 20) begin
      checkEq("busyReady", 32'(reqReady), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    checkEq("latency", lat, LAT + 1);
    checkEq("rspErr", 32'(rspErr), 32'(expErr));
    checkEq("rspRdata", rspRdata, expData);

    if (hold > 0) begin
      rspReady = 1'b0;
      // Stray request while busy must be ignored
      reqValid = 1'b1; reqWr = 1'b1; reqAddr = 32'($urandom_range(0, 15)) * 4;
      reqBe = 4'hF; reqWdata = $urandom;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checkEq("holdValid", 32'(rspValid), 32'd1);
        checkEq("holdRdata", rspRdata, expData);
        checkEq("holdErr", 32'(rspErr), 32'(expErr));
        checkEq("holdReady", 32'(reqReady), 32'd0);
      end
      reqValid = 1'b0;
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    checkEq("dropValid", 32'(rspValid), 32'd0);
    checkEq("idleReady", 32'(reqReady), 32'd1);
  endtask

  initial begin
    bit          ok;
    int          sel;
    logic [31:0] a;
    clearModel();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkEq("rstReqReady", 32'(reqReady), 32'd0);
    checkEq("rstRspValid", 32'(rspValid), 32'd0);
    checkEq("rstRdata", rspRdata, 32'd0);
    checkEq("rstErr", 32'(rspErr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkEq("relReqReady", 32'(reqReady), 32'd1);
    checkEq("relRspValid", 32'(rspValid), 32'd0);

    // Directed cases
    doTxn(1'b0, 32'h0,    4'hF, 32'h0,        0, 1'b0);
    doTxn(1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 0, 1'b0);
    doTxn(1'b0, 32'h10,   4'hF, 32'h0,        0, 1'b1);
    doTxn(1'b1, 32'h10,   4'h3, 32'h12345678, 1, 1'b0);
    doTxn(1'b0, 32'h10,   4'h0, 32'h0,        0, 1'b0);
    doTxn(1'b1, 32'h10,   4'h0, 32'hFFFFFFFF, 0, 1'b0);
    doTxn(1'b0, 32'h10,   4'hF, 32'h0,        0, 1'b0);
    doTxn(1'b0, 32'h13,   4'hF, 32'h0,        0, 1'b0);
    doTxn(1'b0, 32'h1000, 4'hF, 32'h0,        0, 1'b0);
    doTxn(1'b1, 32'h1000, 4'hF, 32'h11111111, 0, 1'b0);
    doTxn(1'b1, 32'h12,   4'hF, 32'h22222222, 0, 1'b0);
    doTxn(1'b1, 32'hFFC,  4'hF, 32'hCAFEF00D, 0, 1'b0);
    doTxn(1'b0, 32'hFFC,  4'hF, 32'h0,        0, 1'b0);
    doTxn(1'b0, 32'h10,   4'hF, 32'h0,        5, 1'b0);
    checkEq("modelWord10", model[4], 32'hDEAD5678);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, 15)) * 4;
      else if (sel == 7) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) a = ($urandom_range(0, 1) == 0) ? 32'hFFC : 32'h1000;
      else               a = $urandom;
      doTxn(1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 3), 1'($urandom));
    end

    // Reset while a store waits: it must never land
    reqValid = 1'b1; reqWr = 1'b1; reqAddr = 32'h20; reqBe = 4'hF; reqWdata = 32'hA5A5A5A5;
    waitAccept(ok);
    checkEq("rstAccept", 32'(ok), 32'd1);
    reqValid = 1'b0;
    @(posedge clk); #1;
    checkEq("rstWaitValid", 32'(rspValid), 32'd0);
    reset = 1'b0;
    #1;
    checkEq("rstMidReady", 32'(reqReady), 32'd0);
    checkEq("rstMidValid", 32'(rspValid), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    clearModel();
    @(posedge clk); #1;
    checkEq("rstMidRel", 32'(reqReady), 32'd1);
    doTxn(1'b0, 32'h20, 4'hF, 32'h0, 0, 1'b0);
    doTxn(1'b0, 32'h10, 4'hF, 32'h0, 0, 1'b0);
    doTxn(1'b0, 32'hFFC, 4'hF, 32'h0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule : tb_dm_responder
`default_nettype wire
